count_pwm_gen: RTL and testbench
================================

# count_pwm_gen

Downstream stage of the free-running n-bit up counter: consumes the counter's count value and generates a registered PWM waveform whose high time is set by a duty value. Duty updates arrive over a valid/ready handshake and are double-buffered, so they take effect only at a period boundary (count returning to 0). This avoids glitched or truncated pulses. The block also emits a one-cycle period-start strobe for downstream sequencing.

## Interface
- n, default 4: width of count and duty; period is 2^n clock cycles when the counter free-runs.
- clk  input  1  rising-edge clock; the same clock drives the up counter.
- reset  input  1  asynchronous, active-high reset.
- count  input  n  current value from the up counter, synchronous to clk.
- enable  input  1  when 0, pwm is forced low; handshake and boundary tracking continue.
- duty_in  input  n  requested duty, in clock cycles high per period.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  registered; 1 = pending buffer empty, a duty value can be accepted.
- duty_active  output  n  duty value currently in force.
- pwm  output  1  registered PWM output.
- period_start  output  1  registered one-cycle strobe marking the first cycle of each period.

## Operation
- Internal state:
  - count_prev (n bits)
  - started flag
  - pending register (n bits) plus pending_full flag
  - duty_active register
- Boundary detection (combinational, per cycle): boundary = (count == 0) && ((count_prev != 0) || !started).
  - The first 0 after reset is a boundary.
  - A counter reset mid-period (jump to 0) is also a boundary.
  - count held at 0 yields a single boundary only.
- count_prev <= count every cycle. started <= 1 on the first boundary and stays 1 until reset.
- Handshake:
  - Accept occurs when duty_valid && duty_ready. On accept, pending <= duty_in, pending_full <= 1, duty_ready <= 0.
  - duty_in is ignored when duty_ready = 0, and during reset.
- Apply: on a boundary with pending_full = 1, duty_active <= pending, pending_full <= 0, duty_ready <= 1.
- Effective duty for the comparison: duty_eff = (boundary && pending_full) ? pending : duty_active.
- Simultaneous accept and boundary: this can occur only with pending empty. The accepted value goes into pending and waits for the next boundary; duty_active is unchanged.
- pwm <= enable && (count < duty_eff), compared unsigned at n bits.
  - duty = 0 gives pwm constantly 0.
  - duty = 2^n-1 gives pwm high for 2^n-1 of 2^n cycles. 100% duty is not supported.
- period_start <= boundary.
- enable low:
  - pwm is 0 from the next cycle.
  - duty_active and pending update normally.
  - period_start still pulses.

## Timing
- Reset values:
  - pwm = 0, period_start = 0
  - duty_active = 0
  - duty_ready = 1, pending_full = 0
  - count_prev = 0, started = 0
- Latency:
  - pwm and period_start lag count by exactly 1 clock.
  - period_start is high in the same cycle that pwm reflects the comparison for count = 0.
- A new duty affects pwm starting with the cycle after the boundary at which it is applied. duty_active changes on that same edge.
- Handshake throughput: at most one duty value per period. duty_ready stays 0 from the accept edge until the next boundary edge.
- Reset mid-operation:
  - All state returns to reset values asynchronously, and the pending value is discarded.
  - After reset release, the first count == 0 is treated as a boundary.
- Count wrap from 2^n-1 to 0 is the normal boundary. No boundary occurs at any other value.

## Test plan
- **Reset and first period.** Setup: n=4, counter free-running, reset released, no duty written. Required:
  - period_start pulses one cycle after count = 0 is first seen.
  - pwm stays 0 throughout.
  - duty_ready = 1.
- **Duty load.** Stimulus: with count = 5, drive duty_in = 6, duty_valid = 1 for one cycle. Required:
  - duty_ready goes 0 on the next cycle.
  - duty_active stays 0 until after the count 15→0 wrap, then becomes 6 and duty_ready returns to 1.
  - From then, pwm is high exactly 6 cycles per 16: the cycles following count 0..5.
- **Back-to-back request.** Stimulus: with pending full, offer duty_in = 3. Required:
  - Not accepted (duty_ready = 0).
  - Re-offered after the boundary, it applies at the following boundary.
- **Accept on boundary cycle.** Stimulus: duty_valid with duty_in = 10 presented exactly when count = 0 and pending is empty. Required:
  - duty_active is unchanged for this period.
  - duty_active becomes 10 at the next wrap.
- **Extremes and enable.** Required:
  - duty = 15 gives pwm high 15 of 16 cycles; duty = 0 gives pwm always low.
  - Deasserting enable mid-high forces pwm = 0 the next cycle while period_start keeps pulsing every 16 cycles.
- **Mid-period disturbances.** Stimulus: counter reset at count = 9 with a pending duty of 4. Required:
  - A boundary is detected and duty_active becomes 4.
  - period_start pulses.
- **Block reset mid-operation.** Stimulus: assert reset mid-period. Required:
  - All outputs clear immediately.
  - The pending value is lost.

Source files
------------

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator driven by an external free-running up counter.
// A new duty value is captured over a valid/ready handshake into a one-entry
// pending buffer and only moves into force when the count returns to zero.
// Applying the change only at that point means a pulse is never cut short
// or glitched. A registered one-cycle strobe marks the first cycle of each
// period.
module count_pwm_gen #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] count,
  input  logic         enable,
  input  logic [n-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic [n-1:0] duty_active,
  output logic         pwm,
  output logic         period_start
);

  logic [n-1:0] countPrev_q, countPrev_d;
  logic         started_q, started_d;
  logic [n-1:0] pending_q, pending_d;
  logic         pendingFull_q, pendingFull_d;
  logic [n-1:0] dutyActive_q, dutyActive_d;
  logic         dutyReady_q, dutyReady_d;
  logic         pwm_q, pwm_d;
  logic         periodStart_q, periodStart_d;

  logic         boundary;
  logic         accept;
  logic         applyNow;
  logic [n-1:0] dutyEff;

  // Period-boundary detection and handshake qualification, evaluated every cycle.
  // The first zero after reset counts as a boundary. A jump to zero in mid-period
  // also counts. A count held at zero produces only one boundary.
  always_comb begin
    boundary = (count == '0) && ((countPrev_q != '0) || !started_q);
    accept   = duty_valid && dutyReady_q;
    applyNow = boundary && pendingFull_q;
    dutyEff  = applyNow ? pending_q : dutyActive_q;
  end

  // Next-state logic.
  // Apply and accept never happen in the same cycle: an accept needs the
  // pending buffer to be empty, and an apply needs it to be full.
  always_comb begin
    countPrev_d   = count;
    started_d     = started_q | boundary;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    dutyActive_d  = dutyActive_q;
    dutyReady_d   = dutyReady_q;
    if (applyNow) begin
      dutyActive_d  = pending_q;
      pendingFull_d = 1'b0;
      dutyReady_d   = 1'b1;
    end
    if (accept) begin
      pending_d     = duty_in;
      pendingFull_d = 1'b1;
      dutyReady_d   = 1'b0;
    end
    pwm_d         = enable && (count < dutyEff);
    periodStart_d = boundary;
  end

  // State registers. Reset is asynchronous and also discards any pending duty value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countPrev_q   <= '0;
      started_q     <= 1'b0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      dutyActive_q  <= '0;
      dutyReady_q   <= 1'b1;
      pwm_q         <= 1'b0;
      periodStart_q <= 1'b0;
    end else begin
      countPrev_q   <= countPrev_d;
      started_q     <= started_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      dutyActive_q  <= dutyActive_d;
      dutyReady_q   <= dutyReady_d;
      pwm_q         <= pwm_d;
      periodStart_q <= periodStart_d;
    end
  end

  assign duty_ready   = dutyReady_q;
  assign duty_active  = dutyActive_q;
  assign pwm          = pwm_q;
  assign period_start = periodStart_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// tb_count_pwm_gen: directed and randomized checks of count_pwm_gen against
// a behavioural model. The model tracks the pending duty as a queue and
// decides period starts from the counter values it has observed.
module tb_count_pwm_gen;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       enable;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic [3:0] duty_active;
  logic       pwm;
  logic       period_start;

  int vectors;
  int miscompares;

  // Reference model state.
  int mLastCount;
  bit mStarted;
  int mActive;
  int mPending[$];
  bit expPwm;
  bit expPs;

  logic [3:0] cnt;

  count_pwm_gen #(.n(4)) dut (
    .clk(clk),
    .reset(reset),
    .count(count),
    .enable(enable),
    .duty_in(duty_in),
    .duty_valid(duty_valid),
    .duty_ready(duty_ready),
    .duty_active(duty_active),
    .pwm(pwm),
    .period_start(period_start)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLastCount = 0;
    mStarted   = 0;
    mActive    = 0;
    mPending.delete();
    expPwm     = 0;
    expPs      = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pwm"}, {3'b0, pwm}, {3'b0, expPwm});
    checkOutput({tag, ".period_start"}, {3'b0, period_start}, {3'b0, expPs});
    checkOutput({tag, ".duty_ready"}, {3'b0, duty_ready}, {3'b0, mPending.size() == 0});
    checkOutput({tag, ".duty_active"}, duty_active, mActive[3:0]);
  endtask

  // Drive one cycle of inputs, advance the model, clock the DUT and compare.
  task automatic applyStimulus(input logic [3:0] c, input logic en, input logic v,
                               input logic [3:0] d, input string tag);
    bit bnd;
    bit rdy;
    int eff;
    count      = c;
    enable     = en;
    duty_valid = v;
    duty_in    = d;
    bnd = (c == 0) && (mLastCount != 0 || !mStarted);
    rdy = (mPending.size() == 0);
    eff = (bnd && !rdy) ? mPending[0] : mActive;
    expPwm = en && (int'(c) < eff);
    expPs  = bnd;
    if (bnd) mStarted = 1;
    if (bnd && !rdy) mActive = mPending.pop_front();
    if (v && rdy) mPending.push_back(int'(d));
    mLastCount = int'(c);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  // One free-running counter step.
  task automatic tick(input logic en, input logic v, input logic [3:0] d, input string tag);
    applyStimulus(cnt, en, v, d, tag);
    cnt = cnt + 4'd1;
  endtask

  task automatic runTo(input logic [3:0] target, input logic en, input string tag);
    for (int i = 0; i < 40 && cnt != target; i++) tick(en, 1'b0, 4'd0, tag);
  endtask

  task automatic runCycles(input int n, input logic en, input string tag);
    for (int i = 0; i < n; i++) tick(en, 1'b0, 4'd0, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    count       = 4'd0;
    enable      = 1'b1;
    duty_in     = 4'd0;
    duty_valid  = 1'b0;
    cnt         = 4'd12;
    modelReset();

    // Reset state.
    #12;
    checkAll("reset");
    reset = 1'b0;

    // First period: the first zero gives a strobe; no duty is loaded, so pwm stays low.
    runCycles(24, 1'b1, "first");

    // Duty load of 6 at count 5; it takes effect at the next wrap.
    runTo(4'd5, 1'b1, "pre_load");
    tick(1'b1, 1'b1, 4'd6, "load6");
    runCycles(40, 1'b1, "duty6");

    // Back-to-back: 12 is accepted, 3 is refused while pending is full, then re-offered.
    runTo(4'd2, 1'b1, "pre_b2b");
    tick(1'b1, 1'b1, 4'd12, "load12");
    runTo(4'd7, 1'b1, "b2b_wait");
    tick(1'b1, 1'b1, 4'd3, "offer3_busy");
    runTo(4'd4, 1'b1, "b2b_wrap");
    tick(1'b1, 1'b1, 4'd3, "offer3_again");
    runCycles(36, 1'b1, "duty3");

    // Accept on the boundary cycle itself.
    runTo(4'd0, 1'b1, "pre_bnd");
    tick(1'b1, 1'b1, 4'd10, "load10_bnd");
    runCycles(36, 1'b1, "duty10");

    // Extremes: 15 and 0.
    tick(1'b1, 1'b1, 4'd15, "load15");
    runCycles(36, 1'b1, "duty15");
    tick(1'b1, 1'b1, 4'd0, "load0");
    runCycles(36, 1'b1, "duty0");

    // Enable dropped mid-high; strobes continue.
    tick(1'b1, 1'b1, 4'd15, "load15b");
    runCycles(24, 1'b1, "duty15b");
    runTo(4'd6, 1'b1, "pre_en");
    runCycles(36, 1'b0, "en_low");
    runCycles(20, 1'b1, "en_high");

    // Counter reset to 0 at count 9, with 4 pending.
    runTo(4'd2, 1'b1, "pre_mid");
    tick(1'b1, 1'b1, 4'd4, "load4");
    runTo(4'd9, 1'b1, "mid_wait");
    cnt = 4'd0;
    runCycles(20, 1'b1, "mid_reset");

    // Count held at zero gives one boundary only.
    runTo(4'd0, 1'b1, "pre_hold");
    for (int i = 0; i < 4; i++) applyStimulus(4'd0, 1'b1, 1'b0, 4'd0, "hold0");
    cnt = 4'd1;
    runCycles(18, 1'b1, "after_hold");

    // Block reset mid-period with a pending value that must be lost.
    runTo(4'd3, 1'b1, "pre_rst");
    tick(1'b1, 1'b1, 4'd9, "load9");
    runCycles(3, 1'b1, "pre_rst2");
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll("async_rst");
    @(posedge clk);
    #1;
    checkAll("rst_held");
    reset = 1'b0;
    runCycles(40, 1'b1, "post_rst");

    // Randomized traffic: counter wraps, jumps, holds; random enable and offers.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) cnt = 4'd0;
      else if (r < 4) cnt = 4'($urandom_range(0, 15));
      if (r == 99) begin
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("rnd_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      if (r >= 4 && r < 8) applyStimulus(cnt, 1'b1, 1'b0, 4'd0, "rnd_hold");
      else tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                4'($urandom_range(0, 15)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
